// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcodes, ALUOp / ALUControl codes and datapath mux select codes.
package ctrl_pkg;

  // FETCH must stay at 0: reset lands there and state_o exposes it.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_JAL     = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALUOp (internal between FSM and ALU decoder)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU source A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU source B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // True when funct3 names an ALU operation this core implements
  // for R-type / I-type arithmetic.
  function automatic logic alu_funct3_ok(input logic [2:0] f3, input logic en_xor);
    logic ok;
    case (f3)
      3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
      3'b100:                         ok = en_xor;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_multicycle_alu_dec.sv
// ALU decoder: turns the FSM's ALUOp plus instruction fields into the
// ALUControl code. Unsupported funct3 values fall back to add; the
// top level flags those instructions as illegal before they execute.
module alu_dec
  import ctrl_pkg::*;
#(
  parameter int EN_XOR = 0
) (
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  // Select the ALU operation from ALUOp and, for ALUOp 10, funct3/funct7.
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 && i_funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          3'b100:  o_alu_control = (EN_XOR != 0) ? ALU_XOR : ALU_ADD;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ctrl_multicycle.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared ALU and memory port, plus branch
// decision and immediate-format decode. Write strobes are forced low
// while rst_n is asserted so an aborted instruction leaves no trace.
module ctrl_multicycle
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int EN_BNE   = 0,
  parameter int EN_XOR   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] state_o
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_ready;
  logic       w_dec_illegal;
  logic       w_taken;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic       w_adr_src;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;

  // Without wait states every memory access completes in its first cycle.
  assign w_ready = (MEM_WAIT == 0) || MemReady;

  // Decode-time legality: unknown opcodes, unsupported ALU funct3 and
  // unsupported branch conditions all abort back to FETCH.
  always_comb begin
    w_dec_illegal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL: w_dec_illegal = 1'b0;
      OP_RTYPE, OP_ITYPE:        w_dec_illegal = !alu_funct3_ok(funct3, EN_XOR != 0);
      OP_BRANCH:                 w_dec_illegal = !((funct3 == F3_BEQ) ||
                                                   ((EN_BNE != 0) && (funct3 == F3_BNE)));
      default:                   w_dec_illegal = 1'b1;
    endcase
  end

  // Branch condition from the ALU zero flag (only consulted in BRANCH).
  always_comb begin
    w_taken = 1'b0;
    if (funct3 == F3_BEQ) begin
      w_taken = Zero;
    end else if ((EN_BNE != 0) && (funct3 == F3_BNE)) begin
      w_taken = !Zero;
    end
  end

  // Immediate format straight from the opcode.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  // State register; asynchronous reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore outputs per state.
  always_comb begin
    w_next_state = r_state;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_adr_src    = 1'b0;
    w_result_src = RES_ALUOUT;
    w_alu_src_a  = SRCA_PC;
    w_alu_src_b  = SRCB_RS2;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_ir_write   = w_ready;
        w_pc_update  = w_ready;
        if (w_ready) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
        if (w_dec_illegal) begin
          w_illegal    = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
            OP_RTYPE:          w_next_state = S_EXECR;
            OP_ITYPE:          w_next_state = S_EXECI;
            OP_JAL:            w_next_state = S_JAL;
            OP_BRANCH:         w_next_state = S_BRANCH;
            default:           w_next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = (op == OP_STORE) ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (w_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWR: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (w_ready) w_next_state = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_JAL: begin
        w_alu_src_a  = SRCA_OLDPC;
        w_alu_src_b  = SRCB_FOUR;
        w_pc_update  = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_SUB;
        w_branch     = 1'b1;
        w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  alu_dec #(
    .EN_XOR(EN_XOR)
  ) u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7      (funct7),
    .i_op5         (op[5]),
    .o_alu_control (ALUControl)
  );

  // Strobes are gated by rst_n so reset silences them without a clock edge.
  assign PCWrite   = rst_n && (w_pc_update || (w_branch && w_taken));
  assign IRWrite   = rst_n && w_ir_write;
  assign MemWrite  = rst_n && w_mem_write;
  assign RegWrite  = rst_n && w_reg_write;
  assign Illegal   = rst_n && w_illegal;
  assign AdrSrc    = w_adr_src;
  assign ResultSrc = w_result_src;
  assign ALUSrcA   = w_alu_src_a;
  assign ALUSrcB   = w_alu_src_b;
  assign state_o   = r_state;

endmodule

// File: tb/tb_ctrl_multicycle.sv
// Bench for ctrl_multicycle: a default-parameter instance and a fully
// enabled instance (wait states, bne, xor) share the same stimulus.
// Each instruction's expected per-cycle strobe masks and state trace
// are queued when it is driven and compared when it returns to FETCH.
module tb_ctrl_multicycle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic       mem_ready;
  logic       sel_b;

  logic       a_pcw, a_adr, a_memw, a_irw, a_regw, a_ill;
  logic [1:0] a_rs, a_sa, a_sb, a_imm;
  logic [2:0] a_alu;
  logic [3:0] a_state;
  logic       b_pcw, b_adr, b_memw, b_irw, b_regw, b_ill;
  logic [1:0] b_rs, b_sa, b_sb, b_imm;
  logic [2:0] b_alu;
  logic [3:0] b_state;

  logic       o_pcw, o_adr, o_memw, o_irw, o_regw, o_ill;
  logic [1:0] o_rs;
  logic [2:0] o_alu;
  logic [3:0] o_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_multicycle u_dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(zero), .MemReady(mem_ready),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_memw), .IRWrite(a_irw),
    .RegWrite(a_regw), .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb),
    .ImmSrc(a_imm), .ALUControl(a_alu), .Illegal(a_ill), .state_o(a_state)
  );

  ctrl_multicycle #(.MEM_WAIT(1), .EN_BNE(1), .EN_XOR(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(zero), .MemReady(mem_ready),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_memw), .IRWrite(b_irw),
    .RegWrite(b_regw), .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb),
    .ImmSrc(b_imm), .ALUControl(b_alu), .Illegal(b_ill), .state_o(b_state)
  );

  // Route the instance under test to the common observation signals.
  always_comb begin
    o_pcw   = sel_b ? b_pcw   : a_pcw;
    o_adr   = sel_b ? b_adr   : a_adr;
    o_memw  = sel_b ? b_memw  : a_memw;
    o_irw   = sel_b ? b_irw   : a_irw;
    o_regw  = sel_b ? b_regw  : a_regw;
    o_ill   = sel_b ? b_ill   : a_ill;
    o_rs    = sel_b ? b_rs    : a_rs;
    o_alu   = sel_b ? b_alu   : a_alu;
    o_state = sel_b ? b_state : a_state;
  end

  typedef struct {
    string       name;
    logic        use_b;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic [15:0] mr;      // MemReady per cycle (bit n = cycle n)
    logic [31:0] trace;   // state_o per cycle, one nibble each
    int          cycles;
    logic [2:0]  alu;     // ALUControl in third cycle, 7 if never reached
    logic [15:0] irw, pcw, regw, memw, adr, ill;
    logic [1:0]  rs_last; // ResultSrc in the final cycle
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  function automatic vec_t mk(string nm, logic b, logic [6:0] o, logic [2:0] f3,
                              logic f7, logic z, logic [15:0] mr, logic [31:0] tr,
                              int cyc, logic [2:0] alu, logic [15:0] irw,
                              logic [15:0] pcw, logic [15:0] regw, logic [15:0] memw,
                              logic [15:0] adr, logic [15:0] ill, logic [1:0] rs);
    vec_t v;
    v.name = nm; v.use_b = b; v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z; v.mr = mr;
    v.trace = tr; v.cycles = cyc; v.alu = alu; v.irw = irw; v.pcw = pcw;
    v.regw = regw; v.memw = memw; v.adr = adr; v.ill = ill; v.rs_last = rs;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one instruction, observe it until it returns to FETCH, compare.
  task automatic run_instr(input vec_t v);
    vec_t        e;
    logic [31:0] tr;
    logic [15:0] irw, pcw, regw, memw, adr, ill;
    logic [2:0]  alu;
    logic [1:0]  rs;
    logic [3:0]  st;
    int          cyc;
    bit          done;
    sb_q.push_back(v);
    sel_b = v.use_b; op = v.op; funct3 = v.f3; funct7 = v.f7; zero = v.zero;
    tr = '0; irw = '0; pcw = '0; regw = '0; memw = '0; adr = '0; ill = '0;
    alu = 3'b111; rs = 2'b11; cyc = 0; done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      mem_ready = v.mr[c];
      @(negedge clk);
      st = o_state;
      tr = {tr[27:0], st};
      irw[c] = o_irw; pcw[c] = o_pcw; regw[c] = o_regw;
      memw[c] = o_memw; adr[c] = o_adr; ill[c] = o_ill;
      if (c == 2) alu = o_alu;
      rs = o_rs;
      cyc++;
      @(posedge clk); #1;
      if (o_state == 4'd0 && st != 4'd0) done = 1'b1;
    end
    chk({v.name, ".done"}, 32'(done), 32'd1);
    if (sb_q.size() == 0) begin
      chk({v.name, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.name, ".trace"},  tr,          e.trace);
      chk({e.name, ".cycles"}, 32'(cyc),    32'(e.cycles));
      chk({e.name, ".alu"},    32'(alu),    32'(e.alu));
      chk({e.name, ".irw"},    32'(irw),    32'(e.irw));
      chk({e.name, ".pcw"},    32'(pcw),    32'(e.pcw));
      chk({e.name, ".regw"},   32'(regw),   32'(e.regw));
      chk({e.name, ".memw"},   32'(memw),   32'(e.memw));
      chk({e.name, ".adr"},    32'(adr),    32'(e.adr));
      chk({e.name, ".ill"},    32'(ill),    32'(e.ill));
      chk({e.name, ".rs"},     32'(rs),     32'(e.rs_last));
      $display("txn %-10s dut=%s cycles=%0d trace=%0h", e.name,
               e.use_b ? "b" : "a", cyc, tr);
    end
  endtask

  initial begin
    // Default instance (MemReady held low to show it is ignored)
    tbl.push_back(mk("lw",     0, 7'h03, 3'd2, 0, 0, 16'h0000, 32'h01234, 5, 3'd0, 16'h1, 16'h1, 16'h10, 16'h0, 16'h08, 16'h0, 2'b01));
    tbl.push_back(mk("sw",     0, 7'h23, 3'd2, 0, 0, 16'h0000, 32'h0125,  4, 3'd0, 16'h1, 16'h1, 16'h0,  16'h8, 16'h08, 16'h0, 2'b00));
    tbl.push_back(mk("add",    0, 7'h33, 3'd0, 0, 0, 16'h0000, 32'h0169,  4, 3'd0, 16'h1, 16'h1, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("sub",    0, 7'h33, 3'd0, 1, 0, 16'h0000, 32'h0169,  4, 3'd1, 16'h1, 16'h1, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("and",    0, 7'h33, 3'd7, 0, 0, 16'h0000, 32'h0169,  4, 3'd2, 16'h1, 16'h1, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("or",     0, 7'h33, 3'd6, 0, 0, 16'h0000, 32'h0169,  4, 3'd3, 16'h1, 16'h1, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("slt",    0, 7'h33, 3'd2, 0, 0, 16'h0000, 32'h0169,  4, 3'd5, 16'h1, 16'h1, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("addi_f7",0, 7'h13, 3'd0, 1, 0, 16'h0000, 32'h0179,  4, 3'd0, 16'h1, 16'h1, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("xori_a", 0, 7'h13, 3'd4, 0, 0, 16'h0000, 32'h01,    2, 3'd7, 16'h1, 16'h1, 16'h0,  16'h0, 16'h0,  16'h2, 2'b00));
    tbl.push_back(mk("sll_a",  0, 7'h33, 3'd1, 0, 0, 16'h0000, 32'h01,    2, 3'd7, 16'h1, 16'h1, 16'h0,  16'h0, 16'h0,  16'h2, 2'b00));
    tbl.push_back(mk("jal",    0, 7'h6F, 3'd0, 0, 0, 16'h0000, 32'h0189,  4, 3'd0, 16'h1, 16'h5, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("beq_z1", 0, 7'h63, 3'd0, 0, 1, 16'h0000, 32'h01A,   3, 3'd1, 16'h1, 16'h5, 16'h0,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("beq_z0", 0, 7'h63, 3'd0, 0, 0, 16'h0000, 32'h01A,   3, 3'd1, 16'h1, 16'h1, 16'h0,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("bne_a",  0, 7'h63, 3'd1, 0, 0, 16'h0000, 32'h01,    2, 3'd7, 16'h1, 16'h1, 16'h0,  16'h0, 16'h0,  16'h2, 2'b00));
    tbl.push_back(mk("op7f",   0, 7'h7F, 3'd0, 0, 0, 16'h0000, 32'h01,    2, 3'd7, 16'h1, 16'h1, 16'h0,  16'h0, 16'h0,  16'h2, 2'b00));
    // Fully enabled instance
    tbl.push_back(mk("lw_wait",1, 7'h03, 3'd2, 0, 0, 16'h0044, 32'h00012334, 8, 3'd0, 16'h4, 16'h4, 16'h80, 16'h0, 16'h60, 16'h0, 2'b01));
    tbl.push_back(mk("sw_wait",1, 7'h23, 3'd2, 0, 0, 16'h0011, 32'h01255, 5, 3'd0, 16'h1, 16'h1, 16'h0,  16'h18, 16'h18, 16'h0, 2'b00));
    tbl.push_back(mk("bne_z0", 1, 7'h63, 3'd1, 0, 0, 16'hFFFF, 32'h01A,   3, 3'd1, 16'h1, 16'h5, 16'h0,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("bne_z1", 1, 7'h63, 3'd1, 0, 1, 16'hFFFF, 32'h01A,   3, 3'd1, 16'h1, 16'h1, 16'h0,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("xor",    1, 7'h33, 3'd4, 0, 0, 16'hFFFF, 32'h0169,  4, 3'd4, 16'h1, 16'h1, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));
    tbl.push_back(mk("xori",   1, 7'h13, 3'd4, 0, 0, 16'hFFFF, 32'h0179,  4, 3'd4, 16'h1, 16'h1, 16'h8,  16'h0, 16'h0,  16'h0, 2'b00));

    op = 7'h03; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b1; sel_b = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // While held in reset: FETCH values with write strobes suppressed
    chk("rst.state",   32'(a_state), 32'd0);
    chk("rst.pcwrite", 32'(a_pcw),   32'd0);
    chk("rst.irwrite", 32'(a_irw),   32'd0);
    chk("rst.adrsrc",  32'(a_adr),   32'd0);
    chk("rst.srca",    32'(a_sa),    32'd0);
    chk("rst.srcb",    32'(a_sb),    32'd2);
    chk("rst.ressrc",  32'(a_rs),    32'd2);
    chk("rst.immsrc_i",32'(a_imm),   32'd0);

    rst_n = 1'b1;
    foreach (tbl[i]) run_instr(tbl[i]);

    // Immediate format decode
    op = 7'h23; #1 chk("imm.s", 32'(a_imm), 32'd1);
    op = 7'h63; #1 chk("imm.b", 32'(a_imm), 32'd2);
    op = 7'h6F; #1 chk("imm.j", 32'(a_imm), 32'd3);

    // Reset dropped while the store is stalled in MEMWR
    sel_b = 1'b1; op = 7'h23; funct3 = 3'd2; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.in_memwr",  32'(b_state), 32'd5);
    chk("rstmid.memw_on",   32'(b_memw),  32'd1);
    @(posedge clk); #1;
    chk("rstmid.stalled",   32'(b_state), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.state0",    32'(b_state), 32'd0);
    chk("rstmid.memw_off",  32'(b_memw),  32'd0);
    chk("rstmid.pcw_off",   32'(b_pcw),   32'd0);
    chk("rstmid.irw_off",   32'(b_irw),   32'd0);
    @(posedge clk); #1;
    chk("rstmid.held",      32'(b_state), 32'd0);
    rst_n = 1'b1;
    run_instr(mk("add_rst", 1, 7'h33, 3'd0, 0, 0, 16'hFFFF, 32'h0169, 4, 3'd0,
                 16'h1, 16'h1, 16'h8, 16'h0, 16'h0, 16'h0, 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
